mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single-ported main memory between the instruction-fetch stage and the data-memory (MEM) stage fed by the EX/MEM pipeline register. Sequences each access as a registered request/acknowledge transaction with variable memory latency. Generates the stall signals that freeze the pipeline registers while an access is outstanding, and flags memory timeouts.

## Interface
- ADDR_W, 22, word address width (matches PC / MEM_addr width)
- DATA_W, 32, data width
- ACK_TIMEOUT, 64, max cycles ram_en may stay high without ram_ack before abort
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- hlt  in  1  halt; blocks new grants, in-flight access completes
- if_req  in  1  fetch stage requests instruction word
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched word, valid when if_rdy
- if_rdy  out  1  one-cycle fetch completion pulse
- mem_re, mem_we  in  1 each  MEM-stage read / write request (from MEM_re / MEM_we)
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid when mem_rdy
- mem_rdy  out  1  one-cycle data completion pulse
- ram_en  out  1  memory request, held until ram_ack
- ram_we  out  1  write strobe, qualified by ram_en
- ram_addr  out  ADDR_W  registered memory address
- ram_wdata  out  DATA_W  registered write data
- ram_rdata  in  DATA_W  memory read data, valid with ram_ack
- ram_ack  in  1  memory completion, sampled only while ram_en
- stall_fetch  out  1  hold PC and IF/ID register
- stall_pipe  out  1  hold all pipeline registers through EX/MEM
- mem_err  out  1  sticky timeout flag, cleared only by reset

## Operation
- FSM states: IDLE, MEM_ACC, IF_ACC, DONE.
- IDLE: if hlt, stay. Else if (mem_re|mem_we) and (not last_was_mem or not if_req) -> MEM_ACC. Else if if_req -> IF_ACC. mem_we takes precedence if mem_re and mem_we are both set (write performed).
- Fairness: last_was_mem set on a MEM grant, cleared on an IF grant. Back-to-back contention alternates MEM, IF, MEM, ...
- On grant, register ram_addr, ram_wdata, ram_we, and owner. ram_en goes high in the first cycle of the ACC state and stays high with stable address/data until ram_ack.
- ACC + ram_ack: capture ram_rdata into if_rdata or mem_rdata (mem_rdata is updated only for reads) -> DONE.
- DONE: rdy pulse for owner (mem_rdy on writes too); no grant in DONE -> IDLE. This prevents re-granting the still-visible request.
- Timeout: counter clears on grant and increments each ACC cycle without ack. When it reaches ACK_TIMEOUT, drop ram_en, set mem_err, and go to DONE with rdy pulse and rdata = 0.
- stall_pipe = (mem_re|mem_we) & ~mem_rdy (combinational).
- stall_fetch = stall_pipe | (if_req & ~if_rdy).
- Reset values: all outputs 0, state IDLE, last_was_mem 0, counter 0.

## Timing
- Request visible in cycle 0 (IDLE) -> ram_en from cycle 1 -> ack in cycle k>=1 -> rdy/data in cycle k+1 -> IDLE in cycle k+2.
- Minimum access is 3 cycles of stall-free turnaround; zero-wait memory (ack in cycle 1) gives rdy in cycle 2.
- rdata outputs hold their last value until the next capture.
- ram_ack outside ACC states is ignored.
- hlt rising during ACC does not abort; the access completes and the FSM then parks in IDLE.
- rst_n low mid-access clears ram_en asynchronously. The memory must tolerate an abandoned request.
- Request withdrawn during ACC (e.g. flush): the access still completes, rdy still pulses, and the consumer ignores it.

## Structure
- Package mem_arb_pkg: state enum (IDLE, MEM_ACC, IF_ACC, DONE), owner enum (OWN_IF, OWN_MEM), default ADDR_W/DATA_W constants.
- Single module. The timeout counter is inline ($clog2(ACK_TIMEOUT+1) bits), with no sub-module.

## Test plan
- MEM read at 0x00010, memory acks 2 cycles after ram_en -> ram_en high 2 cycles, mem_rdy pulse with ram_rdata 0xDEADBEEF. stall_pipe high from request until the mem_rdy cycle.
- if_req and mem_we both pending from IDLE with last_was_mem=0 -> MEM write granted first, then IF. A second simultaneous pair -> IF granted first (alternation).
- Zero-wait memory, continuous if_req at PC 0,1,2 -> if_rdy every 3rd cycle with the matching words, and no duplicate grant in DONE.
- hlt asserted one cycle after the IF grant -> access completes and if_rdy pulses. A new if_req gets no grant while hlt is held; the grant follows one cycle after hlt drops.
- ACK_TIMEOUT=4, memory never acks -> ram_en drops after 4 cycles, mem_err stays 1, mem_rdy pulses with mem_rdata 0.
- rst_n pulsed low during MEM_ACC -> ram_en, stalls, and rdy go 0 immediately. After release, state is IDLE and a pending request is re-granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default widths for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int DEF_ADDR_W      = 22;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ACK_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEM_ACC = 2'd1,
        IF_ACC  = 2'd2,
        DONE    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_t;

    // MEM wins unless it won last time and fetch is also waiting.
    function automatic logic grant_mem(input logic mem_req,
                                       input logic if_req,
                                       input logic last_was_mem);
        return mem_req & (~last_was_mem | ~if_req);
    endfunction

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, data-stage and memory-side signals of the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              hlt;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_rdy;

    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdy;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;

    logic              stall_fetch;
    logic              stall_pipe;
    logic              mem_err;

    // Arbiter view: masters the memory bus, answers the pipeline.
    modport master (
        input  hlt,
        input  if_req, if_addr,
        output if_rdata, if_rdy,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_rdy,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata, ram_ack,
        output stall_fetch, stall_pipe, mem_err
    );

    // Environment view: pipeline stages plus the memory itself.
    modport slave (
        output hlt,
        output if_req, if_addr,
        input  if_rdata, if_rdy,
        output mem_re, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_rdy,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata, ram_ack,
        input  stall_fetch, stall_pipe, mem_err
    );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and the MEM
//               stage, with fair alternation, pipeline stalls and ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  wire                clk,
    input  wire                rst_n,
    mem_port_arbiter_if.master bus
);

    localparam int               CNT_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, owner_d;
    logic              last_was_mem_q, last_was_mem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              mem_err_q, mem_err_d;

    logic              w_mem_req;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_timeout;
    logic [DATA_W-1:0] w_cap_data;
    logic              w_if_rdy;
    logic              w_mem_rdy;
    logic              w_stall_pipe;

    assign w_mem_req  = bus.mem_re | bus.mem_we;
    assign w_cnt_inc  = cnt_q + CNT_W'(1);
    assign w_timeout  = (w_cnt_inc == CNT_LIMIT);
    // An aborted access returns zero instead of whatever is on the bus.
    assign w_cap_data = bus.ram_ack ? bus.ram_rdata : '0;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_was_mem_d = last_was_mem_q;
        cnt_d          = cnt_q;
        ram_en_d       = ram_en_q;
        ram_we_d       = ram_we_q;
        ram_addr_d     = ram_addr_q;
        ram_wdata_d    = ram_wdata_q;
        if_rdata_d     = if_rdata_q;
        mem_rdata_d    = mem_rdata_q;
        mem_err_d      = mem_err_q;

        case (state_q)
            IDLE: begin
                if (!bus.hlt) begin
                    if (grant_mem(w_mem_req, bus.if_req, last_was_mem_q)) begin
                        state_d        = MEM_ACC;
                        owner_d        = OWN_MEM;
                        last_was_mem_d = 1'b1;
                        cnt_d          = '0;
                        ram_en_d       = 1'b1;
                        ram_we_d       = bus.mem_we;
                        ram_addr_d     = bus.mem_addr;
                        ram_wdata_d    = bus.mem_wdata;
                    end else if (bus.if_req) begin
                        state_d        = IF_ACC;
                        owner_d        = OWN_IF;
                        last_was_mem_d = 1'b0;
                        cnt_d          = '0;
                        ram_en_d       = 1'b1;
                        ram_we_d       = 1'b0;
                        ram_addr_d     = bus.if_addr;
                    end
                end
            end

            MEM_ACC, IF_ACC: begin
                if (bus.ram_ack || w_timeout) begin
                    state_d  = DONE;
                    ram_en_d = 1'b0;
                    ram_we_d = 1'b0;
                    if (state_q == IF_ACC) begin
                        if_rdata_d = w_cap_data;
                    end else if (!ram_we_q) begin
                        mem_rdata_d = w_cap_data;
                    end
                    if (!bus.ram_ack) begin
                        mem_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = w_cnt_inc;
                end
            end

            // The requester still sees its request here; skipping the grant
            // keeps the same access from being issued twice.
            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            owner_q        <= OWN_IF;
            last_was_mem_q <= 1'b0;
            cnt_q          <= '0;
            ram_en_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            if_rdata_q     <= '0;
            mem_rdata_q    <= '0;
            mem_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_was_mem_q <= last_was_mem_d;
            cnt_q          <= cnt_d;
            ram_en_q       <= ram_en_d;
            ram_we_q       <= ram_we_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
            if_rdata_q     <= if_rdata_d;
            mem_rdata_q    <= mem_rdata_d;
            mem_err_q      <= mem_err_d;
        end
    end

    assign w_if_rdy  = (state_q == DONE) && (owner_q == OWN_IF);
    assign w_mem_rdy = (state_q == DONE) && (owner_q == OWN_MEM);

    // Stalls are gated by reset so the pipeline is released while held.
    assign w_stall_pipe = rst_n & w_mem_req & ~w_mem_rdy;

    assign bus.if_rdy      = w_if_rdy;
    assign bus.mem_rdy     = w_mem_rdy;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.mem_rdata   = mem_rdata_q;
    assign bus.ram_en      = ram_en_q;
    assign bus.ram_we      = ram_we_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.mem_err     = mem_err_q;
    assign bus.stall_pipe  = w_stall_pipe;
    assign bus.stall_fetch = w_stall_pipe | (rst_n & bus.if_req & ~w_if_rdy);

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench for mem_port_arbiter with a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW  = 22;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACK_TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 22'h10) return 32'hDEADBEEF;
        return 32'hC0DE0000 | {10'd0, a};
    endfunction

    // Memory responder: acks once ram_en has been high for lat cycles (0 = never).
    int lat      = 1;
    int en_age   = 0;
    bit stray    = 1'b0;
    initial begin
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ram_en) en_age++;
            else en_age = 0;
            bus.ram_ack   = stray || (bus.ram_en && lat != 0 && en_age == lat);
            bus.ram_rdata = bus.ram_ack ? mem_word(bus.ram_addr) : 32'h0BAD0BAD;
        end
    end

    // Transaction model: grant cycle g, active cycles g+1..e, rdy at e+1.
    bit            mb_busy, mb_mem, mb_we, m_lwm, m_err;
    int            mb_g, mb_e;
    logic [AW-1:0] mb_addr;
    logic [DW-1:0] mb_wdata, m_if_rd, m_mem_rd;

    always @(negedge clk) begin
        bit act, ir, mr, sp, sf;
        if (!rst_n) begin
            mb_busy = 1'b0; m_lwm = 1'b0; m_err = 1'b0;
            m_if_rd = '0;   m_mem_rd = '0;
            chk("rst_ram_en", bus.ram_en, 0);
            chk("rst_ram_we", bus.ram_we, 0);
            chk("rst_ram_addr", bus.ram_addr, 0);
            chk("rst_rdy", {bus.if_rdy, bus.mem_rdy}, 0);
            chk("rst_stall", {bus.stall_fetch, bus.stall_pipe}, 0);
            chk("rst_err", bus.mem_err, 0);
            chk("rst_rdata", {bus.if_rdata, bus.mem_rdata}, 0);
        end else begin
            act = mb_busy && cyc > mb_g && (mb_e < 0 || cyc <= mb_e);
            ir  = mb_busy && mb_e >= 0 && cyc == mb_e + 1 && !mb_mem;
            mr  = mb_busy && mb_e >= 0 && cyc == mb_e + 1 && mb_mem;
            sp  = (bus.mem_re | bus.mem_we) && !mr;
            sf  = sp || (bus.if_req && !ir);
            chk("ram_en", bus.ram_en, act);
            chk("if_rdy", bus.if_rdy, ir);
            chk("mem_rdy", bus.mem_rdy, mr);
            chk("stall_pipe", bus.stall_pipe, sp);
            chk("stall_fetch", bus.stall_fetch, sf);
            chk("mem_err", bus.mem_err, m_err);
            chk("if_rdata", bus.if_rdata, m_if_rd);
            chk("mem_rdata", bus.mem_rdata, m_mem_rd);
            if (act) begin
                chk("ram_addr", bus.ram_addr, mb_addr);
                chk("ram_we", bus.ram_we, mb_we);
                if (mb_we) chk("ram_wdata", bus.ram_wdata, mb_wdata);
            end

            if (act && (bus.ram_ack || cyc - mb_g == TMO)) begin
                mb_e = cyc;
                if (!bus.ram_ack) m_err = 1'b1;
                if (!mb_mem) m_if_rd = bus.ram_ack ? bus.ram_rdata : '0;
                else if (!mb_we) m_mem_rd = bus.ram_ack ? bus.ram_rdata : '0;
            end else if (mb_busy && mb_e >= 0 && cyc == mb_e + 1) begin
                mb_busy = 1'b0;
            end else if (!mb_busy && !bus.hlt) begin
                if ((bus.mem_re || bus.mem_we) && (!m_lwm || !bus.if_req)) begin
                    mb_busy = 1'b1; mb_mem = 1'b1; m_lwm = 1'b1;
                    mb_we = bus.mem_we; mb_addr = bus.mem_addr; mb_wdata = bus.mem_wdata;
                    mb_g = cyc; mb_e = -1;
                end else if (bus.if_req) begin
                    mb_busy = 1'b1; mb_mem = 1'b0; m_lwm = 1'b0;
                    mb_we = 1'b0; mb_addr = bus.if_addr;
                    mb_g = cyc; mb_e = -1;
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input bit is_mem, output int en_cyc, output int st_cyc, output bit seen);
        en_cyc = 0; st_cyc = 0; seen = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(negedge clk);
            if (is_mem ? bus.mem_rdy : bus.if_rdy) seen = 1'b1;
            else begin
                en_cyc += int'(bus.ram_en);
                st_cyc += int'(is_mem ? bus.stall_pipe : bus.stall_fetch);
            end
        end
    endtask

    int en_n, st_n, order, n_rdy, prev_cyc;
    bit seen;

    initial begin
        rst_n = 1'b0;
        bus.hlt = 1'b0; bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_re = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        repeat (3) next();
        rst_n = 1'b1;
        next(); next();
        chk("post_rst_err", bus.mem_err, 0);

        // MEM read, ack on the second ram_en cycle
        lat = 2;
        bus.mem_re = 1'b1; bus.mem_addr = 22'h10;
        wait_rdy(1'b1, en_n, st_n, seen);
        chk("t1_seen", seen, 1);
        chk("t1_rdata", bus.mem_rdata, 32'hDEADBEEF);
        chk("t1_stall_at_rdy", bus.stall_pipe, 0);
        chk("t1_en_cycles", en_n, 2);
        chk("t1_stall_cycles", st_n, 3);
        next(); bus.mem_re = 1'b0;

        // Zero-wait fetch stream PC 0,1,2
        next();
        lat = 1; bus.if_req = 1'b1; bus.if_addr = '0;
        n_rdy = 0; en_n = 0; prev_cyc = 0;
        for (int i = 0; i < 15 && n_rdy < 3; i++) begin
            @(negedge clk);
            en_n += int'(bus.ram_en);
            if (bus.if_rdy) begin
                chk("t3_word", bus.if_rdata, mem_word(AW'(n_rdy)));
                if (n_rdy > 0) chk("t3_gap", cyc - prev_cyc, 3);
                prev_cyc = cyc;
                n_rdy++;
                next();
                if (n_rdy < 3) bus.if_addr = AW'(n_rdy);
                else bus.if_req = 1'b0;
            end
        end
        chk("t3_count", n_rdy, 3);
        chk("t3_en_cycles", en_n, 3);

        // Continuous contention: MEM write vs fetch alternate M,I,M,I
        next();
        bus.if_req = 1'b1; bus.if_addr = 22'h5;
        bus.mem_we = 1'b1; bus.mem_addr = 22'h20; bus.mem_wdata = 32'h12345678;
        order = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.mem_rdy) order = order * 10 + 2;
            if (bus.if_rdy) begin
                order = order * 10 + 1;
                chk("t2_if_rdata", bus.if_rdata, mem_word(22'h5));
            end
        end
        chk("t2_order", order, 2121);
        next(); bus.if_req = 1'b0; bus.mem_we = 1'b0;

        // hlt during an access, then blocking and release
        next();
        lat = 2; bus.if_req = 1'b1; bus.if_addr = 22'h7;
        next(); bus.hlt = 1'b1;
        wait_rdy(1'b0, en_n, st_n, seen);
        chk("t4_seen", seen, 1);
        chk("t4_rdata", bus.if_rdata, mem_word(22'h7));
        chk("t4_en_cycles", en_n, 2);
        next(); bus.if_req = 1'b0;
        next(); bus.if_req = 1'b1; bus.if_addr = 22'h8;
        en_n = 0;
        repeat (4) begin @(negedge clk); en_n += int'(bus.ram_en); end
        chk("t4_hlt_block", en_n, 0);
        next(); bus.hlt = 1'b0;
        @(negedge clk); chk("t4_en_release", bus.ram_en, 0);
        @(negedge clk); chk("t4_en_granted", bus.ram_en, 1);
        wait_rdy(1'b0, en_n, st_n, seen);
        chk("t4_seen2", seen, 1);
        chk("t4_rdata2", bus.if_rdata, mem_word(22'h8));
        next(); bus.if_req = 1'b0;

        // Timeout: memory never acks
        next();
        lat = 0; bus.mem_re = 1'b1; bus.mem_addr = 22'h33;
        wait_rdy(1'b1, en_n, st_n, seen);
        chk("t5_seen", seen, 1);
        chk("t5_en_cycles", en_n, 4);
        chk("t5_rdata_zero", bus.mem_rdata, 0);
        chk("t5_err", bus.mem_err, 1);
        next(); bus.mem_re = 1'b0;
        repeat (3) next();
        chk("t5_err_sticky", bus.mem_err, 1);

        // Stray ack while idle must not be captured
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        repeat (2) next();
        chk("t6_mem_rdata_hold", bus.mem_rdata, 0);
        chk("t6_if_rdata_hold", bus.if_rdata, mem_word(22'h8));

        // Reset in the middle of a MEM access
        lat = 0; bus.mem_re = 1'b1; bus.mem_addr = 22'h44;
        next(); next();
        chk("t7_en_before", bus.ram_en, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_en_async", bus.ram_en, 0);
        chk("t7_stall_async", {bus.stall_fetch, bus.stall_pipe}, 0);
        chk("t7_rdy_async", bus.mem_rdy, 0);
        chk("t7_err_cleared", bus.mem_err, 0);
        lat = 2;
        next(); rst_n = 1'b1;
        wait_rdy(1'b1, en_n, st_n, seen);
        chk("t7_seen", seen, 1);
        chk("t7_en_cycles", en_n, 2);
        chk("t7_rdata", bus.mem_rdata, mem_word(22'h44));
        next(); bus.mem_re = 1'b0;

        repeat (3) next();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
